// File: rtl/axis_rr_arbiter.sv
// Packet-level round-robin arbiter: merges NUM_SRC AXI-Stream sources into one
// registered AXI-Stream master. A grant is taken in IDLE and held until the
// tlast beat of the granted source is accepted, so packets never interleave.
// m_tid carries the index of the source that produced each output beat.
//
// Handshake semantics (both sides): a beat transfers on a rising edge where
// tvalid && tready are both high. A source keeps tvalid and its payload
// stable until the transfer; tready never depends on any tvalid, only on the
// grant state and the fullness of the output register.
module axis_rr_arbiter #(
    parameter int NUM_SRC  = 4,
    parameter int DWIDTH   = 32,
    parameter int ID_WIDTH = (NUM_SRC > 1) ? $clog2(NUM_SRC) : 1
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [NUM_SRC-1:0]            s_tvalid,
    output logic [NUM_SRC-1:0]            s_tready,
    input  logic [NUM_SRC*DWIDTH-1:0]     s_tdata,
    input  logic [NUM_SRC*DWIDTH/8-1:0]   s_tkeep,
    input  logic [NUM_SRC-1:0]            s_tlast,
    output logic                          m_tvalid,
    input  logic                          m_tready,
    output logic [DWIDTH-1:0]             m_tdata,
    output logic [DWIDTH/8-1:0]           m_tkeep,
    output logic                          m_tlast,
    output logic [ID_WIDTH-1:0]           m_tid,
    output logic [31:0]                   pkt_cnt,
    output logic                          busy
);

    localparam int KWIDTH = DWIDTH / 8;

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [ID_WIDTH-1:0] ptr;
    logic [ID_WIDTH-1:0] ptr_nxt;
    logic [ID_WIDTH-1:0] g;
    logic [ID_WIDTH-1:0] g_nxt;

    logic                out_free;
    logic                accept;
    logic                sel_valid;
    logic                sel_last;
    logic [DWIDTH-1:0]   sel_data;
    logic [KWIDTH-1:0]   sel_keep;
    logic [ID_WIDTH-1:0] pick;
    logic                pick_found;

    // (base + k) modulo NUM_SRC, for base in 0..NUM_SRC-1 and k in 0..NUM_SRC
    function automatic logic [ID_WIDTH-1:0] wrap_add(input logic [ID_WIDTH-1:0] base,
                                                     input int k);
        int sum;
        sum = int'(base) + k;
        if (sum >= NUM_SRC) begin
            sum = sum - NUM_SRC;
        end
        return ID_WIDTH'(sum);
    endfunction

    // Output register can take a new beat when empty or draining this cycle
    assign out_free = !m_tvalid || m_tready;
    assign busy     = (state == BUSY);

    // Select the granted source's stream signals
    always_comb begin
        sel_valid = 1'b0;
        sel_last  = 1'b0;
        sel_data  = '0;
        sel_keep  = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            if (g == ID_WIDTH'(i)) begin
                sel_valid = s_tvalid[i];
                sel_last  = s_tlast[i];
                sel_data  = s_tdata[i*DWIDTH +: DWIDTH];
                sel_keep  = s_tkeep[i*KWIDTH +: KWIDTH];
            end
        end
    end

    // Only the granted source sees tready, and only while BUSY
    always_comb begin
        s_tready = '0;
        for (int i = 0; i < NUM_SRC; i++) begin
            s_tready[i] = (state == BUSY) && (g == ID_WIDTH'(i)) && out_free;
        end
    end

    assign accept = (state == BUSY) && sel_valid && out_free;

    // Round-robin search starting at ptr: first valid source wins
    always_comb begin
        pick       = '0;
        pick_found = 1'b0;
        for (int k = 0; k < NUM_SRC; k++) begin
            if (!pick_found && s_tvalid[wrap_add(ptr, k)]) begin
                pick       = wrap_add(ptr, k);
                pick_found = 1'b1;
            end
        end
    end

    // Grant FSM next-state: lock grant in IDLE, release on accepted tlast
    always_comb begin
        state_nxt = state;
        g_nxt     = g;
        ptr_nxt   = ptr;
        case (state)
            IDLE: begin
                if (pick_found) begin
                    g_nxt     = pick;
                    state_nxt = BUSY;
                end
            end
            BUSY: begin
                if (accept && sel_last) begin
                    state_nxt = IDLE;
                    ptr_nxt   = wrap_add(g, 1);
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // Grant FSM state, grant index and round-robin pointer registers
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            state <= IDLE;
            ptr   <= '0;
            g     <= '0;
        end else begin
            state <= state_nxt;
            ptr   <= ptr_nxt;
            g     <= g_nxt;
        end
    end

    // Output register slice: load on accept, drain when taken downstream
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            m_tvalid <= 1'b0;
            m_tdata  <= '0;
            m_tkeep  <= '0;
            m_tlast  <= 1'b0;
            m_tid    <= '0;
        end else if (accept) begin
            m_tvalid <= 1'b1;
            m_tdata  <= sel_data;
            m_tkeep  <= sel_keep;
            m_tlast  <= sel_last;
            m_tid    <= g;
        end else if (m_tready) begin
            m_tvalid <= 1'b0;
        end
    end

    // Count packets as their tlast beat leaves the master port
    always_ff @(posedge aclk or negedge aresetn) begin
        if (!aresetn) begin
            pkt_cnt <= '0;
        end else if (m_tvalid && m_tready && m_tlast) begin
            pkt_cnt <= pkt_cnt + 32'd1;
        end
    end

endmodule

// File: doc/axis_rr_arbiter.md
# axis_rr_arbiter

Packet-level round-robin arbiter that merges NUM_SRC AXI-Stream sources into one AXI-Stream master for the Gold-transmitter datapath. A grant is taken at a packet boundary and held until the beat with tlast is accepted, so packets are never interleaved. The output is one registered stage carrying the winning source index on tid. A wrapping packet counter is exposed for status.

## Interface
- NUM_SRC, 4, number of source streams (≥1)
- DWIDTH, 32, tdata width in bits (multiple of 8)
- ID_WIDTH, derived: max(1, $clog2(NUM_SRC)), width of m_tid
- aclk  in  1  clock; all logic on rising edge
- aresetn  in  1  asynchronous, active-low reset
- s_tvalid  in  NUM_SRC  per-source valid
- s_tready  out  NUM_SRC  per-source ready
- s_tdata  in  NUM_SRC*DWIDTH  source i occupies bits [i*DWIDTH +: DWIDTH]
- s_tkeep  in  NUM_SRC*DWIDTH/8  source i occupies bits [i*DWIDTH/8 +: DWIDTH/8]
- s_tlast  in  NUM_SRC  per-source end of packet
- m_tvalid  out  1  registered output valid
- m_tready  in  1  downstream ready
- m_tdata  out  DWIDTH  registered data
- m_tkeep  out  DWIDTH/8  registered keep
- m_tlast  out  1  registered last
- m_tid  out  ID_WIDTH  index of the source that produced the beat
- pkt_cnt  out  32  packets delivered at master, wraps modulo 2^32
- busy  out  1  high while a grant is held (state BUSY)

## Operation
- State machine:
  - IDLE: no grant.
  - BUSY: grant register g is locked to one source.
- Round-robin pointer ptr (ID_WIDTH bits, range 0..NUM_SRC-1).
- In IDLE, if any s_tvalid is high, choose the first i with s_tvalid[i]=1, scanning ptr, ptr+1, … modulo NUM_SRC.
  - Register g<=i. Next state is BUSY.
  - No s_tready is asserted in IDLE.
- In BUSY:
  - s_tready[g] = !m_tvalid || m_tready. All other s_tready bits are 0.
  - A source beat is accepted when s_tvalid[g] && s_tready[g].
  - On acceptance, load the output register: m_tdata/m_tkeep/m_tlast from source g, m_tid<=g, m_tvalid<=1.
- Accepting a beat with s_tlast[g]=1:
  - State returns to IDLE.
  - ptr <= (g+1) mod NUM_SRC.
- If s_tvalid[g] drops mid-packet, the grant is held indefinitely. Other sources wait.
- Output register:
  - m_tvalid clears when m_tready=1 and no new beat is accepted in the same cycle.
  - m_tvalid stays high with a new payload when a beat is accepted in the same cycle that m_tready=1.
  - Payload is held stable while m_tvalid && !m_tready.
- pkt_cnt increments by 1 on each m_tvalid && m_tready && m_tlast.
- busy = (state==BUSY).
- NUM_SRC=1: ptr and g are always 0. The block acts as a one-stage register slice with a one-cycle bubble between packets.
- Reset (aresetn low, at any time including mid-packet):
  - Immediately: state=IDLE, ptr=0, g=0.
  - All outputs 0: s_tready, m_tvalid, m_tdata, m_tkeep, m_tlast, m_tid, pkt_cnt, busy.
  - Any partial packet is discarded. No tlast is generated for it.

## Timing
- Arbitration takes 1 cycle:
  - s_tvalid seen in IDLE at edge k gives busy=1 and s_tready[g] possibly high during cycle k+1.
  - The first source beat can be accepted at edge k+1.
- Latency: a source beat accepted at edge n appears at the master with m_tvalid=1 after edge n (visible in cycle n+1).
- Throughput within a packet is 1 beat/cycle while m_tready=1.
- Between packets, the slave side has a minimum of 1 non-accepting cycle (the IDLE arbitration cycle). The master side therefore shows a 1-cycle m_tvalid gap.
- s_tready depends combinationally on m_tready and m_tvalid only. There is no path from s_tvalid to s_tready.

## Test plan
- Single source, NUM_SRC=4:
  - Stimulus: src 2 sends 3 beats (0xA0, 0xA1, 0xA2, last on 0xA2) with m_tready=1.
  - Response: master shows 0xA0, 0xA1, 0xA2 on consecutive cycles, m_tid=2, m_tlast only on 0xA2, pkt_cnt=1, ptr=3.
- Round-robin fairness:
  - Stimulus: sources 0–3 all valid continuously with 2-beat packets.
  - Response: m_tid sequence 0,0,1,1,2,2,3,3,0,0; exactly 1 idle cycle between packets.
- No interleave:
  - Stimulus: src 1 holds the grant and deasserts tvalid for 5 cycles mid-packet while src 0 is valid.
  - Response: src 0 s_tready stays 0 until src 1's tlast beat is accepted; then src 0 is granted after 1 cycle.
- Backpressure:
  - Stimulus: m_tready held 0 for 4 cycles mid-packet.
  - Response: m_tdata/m_tid stable, s_tready[g]=0, no beat lost or duplicated.
  - Stimulus: m_tready toggled every cycle.
  - Response: all beats delivered in order.
- Reset mid-packet:
  - Stimulus: assert aresetn=0 during beat 2 of 4.
  - Response: all outputs 0 immediately; after release, next grant starts at src 0 and pkt_cnt=0.
- Counter wrap:
  - Stimulus: force pkt_cnt to 0xFFFFFFFF, then deliver one packet.
  - Response: pkt_cnt=0.
